alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle issuing controller that sits on the initiator side of the datapath ALU.
- Accepts one operation request per handshake and latches operand A into the Y-side latch and operand B alongside it.
- Drives the ALU inputs, holds them for the required settle time, captures the 64-bit ALU result into a Z register, then emits write-back beats: GPR, or LO then HI for mul/div.

Parameters:
- MULDIV_WAIT, 2: extra ISSUE cycles granted to mul/div for the long combinational path; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_opcode  in  5  ALU opcode.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_rd  in  4  destination GPR index.
- alu_a  out  32  to ALU A input.
- alu_b  out  32  to ALU B input.
- alu_opcode  out  5  to ALU opcode input.
- alu_c  in  64  ALU result.
- wb_valid  out  1  write-back beat valid, one cycle per beat.
- wb_dest  out  2  00 GPR, 01 LO, 10 HI.
- wb_rd  out  4  GPR index; echoes req_rd on every beat.
- wb_data  out  32  write-back data.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on illegal opcode.

Behaviour:
- Opcodes: Add 00011, Sub 00100, And 00101, Or 00110, Shr 00111, Shra 01000, Shl 01001, Ror 01010, Rol 01011, Mul 01111, Div 10000, Neg 10001, Not 10010. All other codes are illegal.
- Reset (clear=0, async): state IDLE; all outputs 0 except req_ready=1; operand, opcode, rd and Z latches cleared; wait counter 0.
- Reset mid-operation: the in-flight operation is dropped, and no wb_valid or err is produced for it after release.
- Accept: on a clk edge in IDLE with req_valid=1.
  - Latch opcode, a, b and rd.
  - Legal opcode: go to ISSUE and load the counter with MULDIV_WAIT for Mul/Div, 0 otherwise.
  - Illegal opcode: go to ERR.
- ISSUE:
  - alu_a, alu_b and alu_opcode are driven from the latches; they stay stable until the next accept and are never driven combinationally from req_*.
  - Counter > 0: decrement and stay.
  - Counter = 0: capture alu_c into Z[63:0] and go to WB_LO.
  - Duration: 1 cycle for single ops, 1+MULDIV_WAIT cycles for Mul/Div.
- WB_LO: wb_valid=1 and wb_data=Z[31:0].
  - Single op: wb_dest=00, then go to IDLE.
  - Mul/Div: wb_dest=01, then go to WB_HI.
- WB_HI: wb_valid=1, wb_dest=10, wb_data=Z[63:32], then go to IDLE.
- ERR: err=1 for exactly one cycle, no write-back, then go to IDLE.
- Outputs wb_* and err are registered (driven from state and latches). wb_valid=0 implies wb_data=0 and wb_dest=00.
- Latency from the accept edge to the first wb_valid cycle: 1 edge for single ops, 1+MULDIV_WAIT edges for Mul/Div.
- Minimum request spacing:
  - single ops: 3 cycles (IDLE, ISSUE, WB_LO);
  - Mul/Div: 4+MULDIV_WAIT cycles.
- Requests presented while busy are not accepted (req_ready=0). The requester holds req_* until accept, and nothing is buffered.
- The sequencer performs no arithmetic; the Z upper half is ignored for single ops. Neg and Not use only B, but A is still latched and driven.
- Counter width is clog2(MULDIV_WAIT+1), minimum 1 bit.

Test Plan:
- Add, a=5, b=7, rd=3, ALU model attached -> exactly one wb_valid cycle with wb_dest=00, wb_rd=3, wb_data=12; req_ready high again the following cycle.
- Mul, a=0x00010000, b=0x00010000, MULDIV_WAIT=2 -> alu_* stable for 3 cycles; then beat 1 LO data 0x00000000; next cycle beat 2 HI data 0x00000001.
- Div, a=17, b=5, ALU returning {remainder, quotient} -> LO beat 3 then HI beat 2; busy high for 5 cycles total.
- Illegal opcode 11111 -> err=1 for one cycle, wb_valid never asserted; next Or (a=0xF0, b=0x0F) -> GPR beat 0xFF.
- clear pulsed low during the second ISSUE cycle of Mul -> outputs 0 and req_ready=1 immediately; no beat ever appears for that Mul; a following Sub (a=10, b=3) returns 7.
- req_valid held high with two queued requests (Shl a=1 b=4, then Not b=0) -> second accepted only when req_ready=1; exactly two beats, data 0x10 then 0xFFFFFFFF.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue controller for the datapath ALU: latches one request, holds the
// ALU inputs through the settle window, captures the 64-bit result and emits write-back beats.
`timescale 1ns/1ps
module alu_op_sequencer #(
   parameter int MULDIV_WAIT = 2
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [3:0]  req_rd,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_opcode,
   input  logic [63:0] alu_c,
   output logic        wb_valid,
   output logic [1:0]  wb_dest,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        busy,
   output logic        err,
   output logic [2:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are
   // both high; req_ready is high only in IDLE and the requester holds req_* until then.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WB_LO = 3'd2,
      S_WB_HI = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam int CW = (MULDIV_WAIT > 0) ? $clog2(MULDIV_WAIT + 1) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = CW'(MULDIV_WAIT);

   localparam logic [1:0] DEST_GPR = 2'b00;
   localparam logic [1:0] DEST_LO  = 2'b01;
   localparam logic [1:0] DEST_HI  = 2'b10;

   function automatic logic is_legal(input logic [4:0] op);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
         5'd15, 5'd16, 5'd17, 5'd18: is_legal = 1'b1;
         default:                   is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      is_muldiv = (op == 5'd15) || (op == 5'd16);
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      op_q, op_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [3:0]      rd_q, rd_d;
   logic [63:0]     z_q, z_d;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rd_d      = rd_q;
      z_d       = z_q;
      req_ready = 1'b0;
      busy      = 1'b1;
      wb_valid  = 1'b0;
      wb_dest   = DEST_GPR;
      wb_rd     = '0;
      wb_data   = '0;
      err       = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               op_d = req_opcode;
               a_d  = req_a;
               b_d  = req_b;
               rd_d = req_rd;
               if (is_legal(req_opcode)) begin
                  state_d = S_ISSUE;
                  cnt_d   = is_muldiv(req_opcode) ? WAIT_LOAD : '0;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_ISSUE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               z_d     = alu_c;
               state_d = S_WB_LO;
            end
         end
         S_WB_LO: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = z_q[31:0];
            if (is_muldiv(op_q)) begin
               wb_dest = DEST_LO;
               state_d = S_WB_HI;
            end else begin
               wb_dest = DEST_GPR;
               state_d = S_IDLE;
            end
         end
         S_WB_HI: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_dest  = DEST_HI;
            wb_data  = z_q[63:32];
            state_d  = S_IDLE;
         end
         S_ERR: begin
            err     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ALU inputs come only from the latches so they stay frozen until the next accept.
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = op_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: attached ALU model, per-cycle reference
// model of the issue/write-back schedule, directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

   localparam int W = 2;

   localparam logic [4:0] OP_ADD = 5'd3,  OP_SUB = 5'd4,  OP_OR  = 5'd6;
   localparam logic [4:0] OP_SHL = 5'd9,  OP_MUL = 5'd15, OP_DIV = 5'd16, OP_NOT = 5'd18;

   logic        clk = 1'b0;
   logic        clear = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_opcode = '0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [3:0]  req_rd = '0;
   logic [31:0] alu_a, alu_b;
   logic [4:0]  alu_opcode;
   logic [63:0] alu_c;
   logic        wb_valid;
   logic [1:0]  wb_dest;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy, err;
   logic [2:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.MULDIV_WAIT(W)) dut (
      .clk(clk), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy), .err(err), .dbg_state(dbg_state)
   );

   function automatic logic legal_op(input logic [4:0] op);
      return (op >= 5'd3 && op <= 5'd11) || (op >= 5'd15 && op <= 5'd18);
   endfunction

   function automatic logic muldiv_op(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] aa;
      logic [4:0]  s;
      aa = {a, a};
      s  = b[4:0];
      case (op)
         5'd3:  return {32'h0, a + b};
         5'd4:  return {32'h0, a - b};
         5'd5:  return {32'h0, a & b};
         5'd6:  return {32'h0, a | b};
         5'd7:  return {32'h0, a >> s};
         5'd8:  return {32'h0, 32'($signed(a) >>> s)};
         5'd9:  return {32'h0, a << s};
         5'd10: return {32'h0, 32'(aa >> s)};
         5'd11: begin aa = aa << s; return {32'h0, aa[63:32]}; end
         5'd15: return {32'h0, a} * {32'h0, b};
         5'd16: return (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         5'd17: return {32'h0, 32'h0 - b};
         5'd18: return {32'h0, ~b};
         default: return 64'h0;
      endcase
   endfunction

   // Attached ALU; single ops get junk in the upper half, which the sequencer must ignore.
   function automatic logic [63:0] env_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      r = ref_alu(op, a, b);
      if (!muldiv_op(op)) r[63:32] = 32'hDEAD_BEEF;
      return r;
   endfunction

   assign alu_c = env_alu(alu_opcode, alu_a, alu_b);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one expected-output record per cycle, queued at accept time.
   typedef struct packed {
      logic        idle;
      logic        wbv;
      logic [1:0]  dest;
      logic [31:0] data;
      logic        err;
   } exp_t;

   function automatic exp_t mk(input logic idle, input logic wbv, input logic [1:0] dest,
                               input logic [31:0] data, input logic e);
      exp_t x;
      x.idle = idle; x.wbv = wbv; x.dest = dest; x.data = data; x.err = e;
      return x;
   endfunction

   exp_t        exp_q[$];
   exp_t        cur = '{idle: 1'b1, wbv: 1'b0, dest: 2'b00, data: 32'h0, err: 1'b0};
   logic [31:0] m_a = '0, m_b = '0;
   logic [4:0]  m_op = '0;
   logic [3:0]  m_rd = '0;
   logic [63:0] m_r;

   always @(posedge clk or negedge clear) begin
      if (!clear) begin
         exp_q.delete();
         cur  = mk(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
         m_a  = '0; m_b = '0; m_op = '0; m_rd = '0;
      end else begin
         if (cur.idle && req_valid) begin
            m_a = req_a; m_b = req_b; m_op = req_opcode; m_rd = req_rd;
            if (!legal_op(req_opcode)) begin
               exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0, 1'b1));
            end else begin
               m_r = ref_alu(req_opcode, req_a, req_b);
               for (int i = 0; i < (muldiv_op(req_opcode) ? 1 + W : 1); i++)
                  exp_q.push_back(mk(1'b0, 1'b0, 2'b00, 32'h0, 1'b0));
               if (muldiv_op(req_opcode)) begin
                  exp_q.push_back(mk(1'b0, 1'b1, 2'b01, m_r[31:0], 1'b0));
                  exp_q.push_back(mk(1'b0, 1'b1, 2'b10, m_r[63:32], 1'b0));
               end else begin
                  exp_q.push_back(mk(1'b0, 1'b1, 2'b00, m_r[31:0], 1'b0));
               end
            end
         end
         cur = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b1, 1'b0, 2'b00, 32'h0, 1'b0);
      end
   end

   logic [37:0] beat_q[$];
   int          err_cnt  = 0;
   int          busy_cnt = 0;

   always @(negedge clk) begin
      chk("req_ready",  64'(req_ready),  64'(cur.idle));
      chk("busy",       64'(busy),       64'(!cur.idle));
      chk("wb_valid",   64'(wb_valid),   64'(cur.wbv));
      chk("wb_dest",    64'(wb_dest),    64'(cur.dest));
      chk("wb_data",    64'(wb_data),    64'(cur.data));
      chk("wb_rd",      64'(wb_rd),      64'(cur.wbv ? m_rd : 4'h0));
      chk("err",        64'(err),        64'(cur.err));
      chk("alu_a",      64'(alu_a),      64'(m_a));
      chk("alu_b",      64'(alu_b),      64'(m_b));
      chk("alu_opcode", 64'(alu_opcode), 64'(m_op));
      if (wb_valid) beat_q.push_back({wb_dest, wb_rd, wb_data});
      if (err) err_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
      int n;
      req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_rd = rd;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [4:0] legal_tab [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                  5'd15, 5'd16, 5'd17, 5'd18};

   initial begin
      logic [4:0] op;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 64'(req_ready), 64'(1));
      chk("reset_busy",  64'(busy),      64'(0));
      chk("reset_wbv",   64'(wb_valid),  64'(0));
      #2 clear = 1'b1;
      @(posedge clk); #1;

      // Add 5+7 -> one GPR beat of 12 to rd 3
      beat_q.delete();
      send(OP_ADD, 32'd5, 32'd7, 4'd3);
      idle_cycles(6);
      chk("add_nbeats", 64'(beat_q.size()), 64'(1));
      chk("add_beat",   64'(beat_q[0]),     64'({2'b00, 4'd3, 32'd12}));

      // Mul 0x10000*0x10000 -> LO 0, HI 1
      beat_q.delete();
      send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 4'd1);
      idle_cycles(8);
      chk("mul_nbeats", 64'(beat_q.size()), 64'(2));
      chk("mul_lo",     64'(beat_q[0]),     64'({2'b01, 4'd1, 32'h0}));
      chk("mul_hi",     64'(beat_q[1]),     64'({2'b10, 4'd1, 32'h1}));

      // Div 17/5 -> LO quotient 3, HI remainder 2, five busy cycles
      beat_q.delete();
      busy_cnt = 0;
      send(OP_DIV, 32'd17, 32'd5, 4'd2);
      idle_cycles(8);
      chk("div_busy",   64'(busy_cnt),      64'(5));
      chk("div_nbeats", 64'(beat_q.size()), 64'(2));
      chk("div_lo",     64'(beat_q[0]),     64'({2'b01, 4'd2, 32'd3}));
      chk("div_hi",     64'(beat_q[1]),     64'({2'b10, 4'd2, 32'd2}));

      // Illegal opcode then Or
      beat_q.delete();
      err_cnt = 0;
      send(5'h1F, 32'd1, 32'd2, 4'd0);
      idle_cycles(4);
      chk("ill_err",    64'(err_cnt),       64'(1));
      chk("ill_nbeats", 64'(beat_q.size()), 64'(0));
      send(OP_OR, 32'hF0, 32'h0F, 4'd4);
      idle_cycles(4);
      chk("or_nbeats",  64'(beat_q.size()), 64'(1));
      chk("or_beat",    64'(beat_q[0]),     64'({2'b00, 4'd4, 32'hFF}));

      // Reset during the second ISSUE cycle of a Mul, then Sub
      beat_q.delete();
      err_cnt = 0;
      send(OP_MUL, 32'd3, 32'd4, 4'd5);
      @(posedge clk);
      #3 clear = 1'b0;
      #1;
      chk("clr_ready", 64'(req_ready), 64'(1));
      chk("clr_busy",  64'(busy),      64'(0));
      chk("clr_alu_a", 64'(alu_a),     64'(0));
      req_valid = 1'b0;
      @(posedge clk);
      #3 clear = 1'b1;
      idle_cycles(8);
      chk("clr_nbeats", 64'(beat_q.size()), 64'(0));
      chk("clr_err",    64'(err_cnt),       64'(0));
      send(OP_SUB, 32'd10, 32'd3, 4'd6);
      idle_cycles(4);
      chk("sub_beat", 64'(beat_q[0]), 64'({2'b00, 4'd6, 32'd7}));

      // Back-to-back requests with req_valid held high
      beat_q.delete();
      send(OP_SHL, 32'd1, 32'd4, 4'd7);
      send(OP_NOT, 32'd0, 32'd0, 4'd8);
      idle_cycles(6);
      chk("b2b_nbeats", 64'(beat_q.size()), 64'(2));
      chk("b2b_shl",    64'(beat_q[0]),     64'({2'b00, 4'd7, 32'h10}));
      chk("b2b_not",    64'(beat_q[1]),     64'({2'b00, 4'd8, 32'hFFFF_FFFF}));

      // Randomized traffic against the per-cycle model
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 99) < 85) op = legal_tab[$urandom_range(0, 12)];
         else op = 5'($urandom_range(0, 31));
         send(op, $urandom, $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(0, 3));
      end
      idle_cycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
